// File: rtl/pwm_demodulator_if.sv
// Signal bundle between a PWM stream source and the demodulator that recovers
// one duty count per period.
interface pwm_demodulator_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  pwm_in;
  logic [DATA_WIDTH-1:0] sample_data;
  logic                  sample_valid;
  logic                  locked;
  logic                  sync_err;

  modport master (
    output pwm_in,
    input  sample_data, sample_valid, locked, sync_err
  );

  modport slave (
    input  pwm_in,
    output sample_data, sample_valid, locked, sync_err
  );
endinterface

// File: rtl/pwm_demodulator.sv
// Recovers the duty count D of a PWM stream (high for the first D of PWM_STEPS
// clocks) once per period, with framing lock and misaligned-edge detection.
module pwm_demodulator #(
  parameter int unsigned PWM_STEPS  = 255,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  pwm_demodulator_if.slave  bus
);
  localparam int unsigned SLOT_W = $clog2(PWM_STEPS);
  localparam int unsigned TO_W   = $clog2(2 * PWM_STEPS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PWM_STEPS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(2 * PWM_STEPS - 1);

  typedef enum logic {HUNT, TRACK} state_t;

  state_t                state;
  logic                  sync1, pwm_s, pwm_d;
  logic                  rise;
  logic [SLOT_W-1:0]     slot;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] pwm_s_ext;
  logic [TO_W-1:0]       to_cnt;
  logic [DATA_WIDTH-1:0] sample_data_r;
  logic                  sample_valid_r, locked_r, sync_err_r;

  assign rise      = pwm_s & ~pwm_d;
  assign pwm_s_ext = {{(DATA_WIDTH-1){1'b0}}, pwm_s};

  // slot holds the index of the cycle being sampled; acc is the count of high
  // cycles before it. Clearing acc at the period end is equivalent to
  // restarting it from the following slot-0 sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= HUNT;
      sync1          <= 1'b0;
      pwm_s          <= 1'b0;
      pwm_d          <= 1'b0;
      slot           <= '0;
      acc            <= '0;
      to_cnt         <= '0;
      sample_data_r  <= '0;
      sample_valid_r <= 1'b0;
      locked_r       <= 1'b0;
      sync_err_r     <= 1'b0;
    end else begin
      sync1          <= bus.pwm_in;
      pwm_s          <= sync1;
      pwm_d          <= pwm_s;
      sample_valid_r <= 1'b0;
      sync_err_r     <= 1'b0;
      case (state)
        HUNT: begin
          if (rise) begin
            state  <= TRACK;
            slot   <= SLOT_W'(1);
            acc    <= DATA_WIDTH'(1);
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            state  <= TRACK;
            slot   <= '0;
            acc    <= '0;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        TRACK: begin
          if (rise && (slot != '0)) begin
            sync_err_r <= 1'b1;
            locked_r   <= 1'b0;
            slot       <= SLOT_W'(1);
            acc        <= DATA_WIDTH'(1);
          end else if (slot == SLOT_LAST) begin
            sample_data_r  <= acc + pwm_s_ext;
            sample_valid_r <= 1'b1;
            locked_r       <= 1'b1;
            slot           <= '0;
            acc            <= '0;
          end else begin
            slot <= slot + 1'b1;
            acc  <= acc + pwm_s_ext;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  assign bus.sample_data  = sample_data_r;
  assign bus.sample_valid = sample_valid_r;
  assign bus.locked       = locked_r;
  assign bus.sync_err     = sync_err_r;
endmodule

// File: tb/tb_pwm_demodulator.sv
// Scenario bench for pwm_demodulator: streams are built as bit sequences and
// expected outputs come from a window-sum framing model of those sequences.
module tb_pwm_demodulator;
  localparam int P  = 255;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pwm_demodulator_if #(.DATA_WIDTH(DW)) bus ();

  pwm_demodulator #(.PWM_STEPS(P), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit stim[$];
  int ev_valid[], ev_err[], ev_data[], ex_locked[];

  function automatic bit is_rise(int j);
    return stim[j] && (j == 0 || !stim[j-1]);
  endfunction

  // Stream index j is seen by the framing logic at clock edge j+3 (two sync
  // stages plus the registered outputs); expectations are indexed by edge.
  function automatic void build_model();
    int n = stim.size();
    int f;
    bit lk;
    ev_valid  = new[n+1];
    ev_err    = new[n+1];
    ev_data   = new[n+1];
    ex_locked = new[n+1];
    for (int e = 0; e <= n; e++) begin
      ev_valid[e] = 0; ev_err[e] = 0; ev_data[e] = 0; ex_locked[e] = 0;
    end
    f = 2*P - 2;
    for (int j = 0; j <= 2*P - 3 && j < n; j++)
      if (is_rise(j)) begin f = j; break; end
    for (int j = f + 1; j < n; j++) begin
      int ph = (j - f) % P;
      if (is_rise(j) && ph != 0) begin
        f = j;
        if (j + 3 <= n) ev_err[j+3] = 1;
      end else if (ph == P - 1) begin
        int s = 0;
        for (int k = j - P + 1; k <= j; k++) s += int'(stim[k]);
        if (j + 3 <= n) begin ev_valid[j+3] = 1; ev_data[j+3] = s; end
      end
    end
    lk = 0;
    for (int e = 1; e <= n; e++) begin
      if (ev_valid[e] != 0) lk = 1;
      else if (ev_err[e] != 0) lk = 0;
      ex_locked[e] = int'(lk);
    end
  endfunction

  function automatic void add_const(bit v, int n);
    for (int i = 0; i < n; i++) stim.push_back(v);
  endfunction

  function automatic void add_period(int d);
    for (int i = 0; i < P; i++) stim.push_back(i < d);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.pwm_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_stream(input string name);
    build_model();
    for (int c = 0; c < stim.size(); c++) begin
      int e = c + 1;
      bus.pwm_in = stim[c];
      @(posedge clk); #1;
      checks++;
      if (bus.sample_valid !== ev_valid[e][0]) begin
        failures++;
        $display("FAIL %s sample_valid edge=%0d got=%b exp=%0d", name, e, bus.sample_valid, ev_valid[e]);
      end
      checks++;
      if (bus.sync_err !== ev_err[e][0]) begin
        failures++;
        $display("FAIL %s sync_err edge=%0d got=%b exp=%0d", name, e, bus.sync_err, ev_err[e]);
      end
      checks++;
      if (bus.locked !== ex_locked[e][0]) begin
        failures++;
        $display("FAIL %s locked edge=%0d got=%b exp=%0d", name, e, bus.locked, ex_locked[e]);
      end
      if (ev_valid[e] != 0) begin
        checks++;
        if (bus.sample_data !== DW'(ev_data[e])) begin
          failures++;
          $display("FAIL %s sample_data edge=%0d got=%0d exp=%0d", name, e, bus.sample_data, ev_data[e]);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.sample_data !== '0) begin
      failures++; $display("FAIL %s sample_data got=%0d exp=0", name, bus.sample_data);
    end
    checks++;
    if (bus.sample_valid !== 1'b0) begin
      failures++; $display("FAIL %s sample_valid got=%b exp=0", name, bus.sample_valid);
    end
    checks++;
    if (bus.locked !== 1'b0) begin
      failures++; $display("FAIL %s locked got=%b exp=0", name, bus.locked);
    end
    checks++;
    if (bus.sync_err !== 1'b0) begin
      failures++; $display("FAIL %s sync_err got=%b exp=0", name, bus.sync_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pwm_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
  endtask

  task automatic test_constant_duty();
    do_reset();
    stim.delete();
    add_const(0, int'($urandom_range(3, 60)));
    repeat (6) add_period(100);
    add_const(0, 8);
    run_stream("duty100");
  endtask

  task automatic test_zero();
    do_reset();
    stim.delete();
    add_const(0, 2*P + 5*P);
    run_stream("const0");
  endtask

  task automatic test_full();
    do_reset();
    stim.delete();
    add_const(1, 6*P);
    run_stream("const1");
  endtask

  task automatic test_duty_sequence();
    int seq[5] = '{10, 200, 0, 255, 1};
    do_reset();
    stim.delete();
    add_const(0, 5);
    foreach (seq[i]) add_period(seq[i]);
    add_const(0, 10);
    run_stream("dutyseq");
  endtask

  task automatic test_phase_jump();
    int d = int'($urandom_range(20, 200));
    do_reset();
    stim.delete();
    add_const(0, 5);
    repeat (3) add_period(d);
    add_const(0, 37);
    repeat (4) add_period(d);
    add_const(0, 10);
    run_stream("phasejump");
  endtask

  task automatic test_random();
    do_reset();
    stim.delete();
    add_const(0, int'($urandom_range(1, 40)));
    for (int i = 0; i < 12; i++) begin
      add_period(int'($urandom_range(0, P)));
      if ($urandom_range(0, 3) == 0) add_const(0, int'($urandom_range(1, P-1)));
    end
    add_const(0, 10);
    run_stream("random");
  endtask

  task automatic test_reset_mid();
    do_reset();
    stim.delete();
    add_const(0, 5);
    repeat (2) add_period(50);
    for (int i = 0; i < 120; i++) stim.push_back(i < 50);
    run_stream("midrst_pre");
    do_reset();
    #0;
    check_reset_outputs("midrst");
    stim.delete();
    add_const(0, 3);
    repeat (3) add_period(50);
    add_const(0, 10);
    run_stream("midrst_post");
  endtask

  initial begin
    bus.pwm_in = 1'b0;
    test_reset();
    test_constant_duty();
    test_zero();
    test_full();
    test_duty_sequence();
    test_phase_jump();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
